// File: rtl/ecg_layer_sequencer.sv
// ecg_layer_sequencer: steps the shared MAC/ReLU/pool datapath through CONV1, POOL1, CONV2, CONV3, FC.
// Ports: i_clk/i_rst_n (async active-low), i_start/i_stall/i_abort control; o_state debug code,
// o_layer_sel buffer select, o_x_addr/o_w_addr read addresses, o_mac_en/o_mac_clr/o_acc_valid MAC strobes,
// o_pool_en pool strobe, o_busy run-in-progress, o_done one-cycle completion pulse.
module ecg_layer_sequencer #(
  parameter int K        = 3,
  parameter int STRIDE   = 1,
  parameter int OUT1     = 4,
  parameter int POOL_LEN = 2,
  parameter int OUT2     = 2,
  parameter int OUT3     = 2,
  parameter int FC_LEN   = 4,
  parameter int ADDR_W   = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_stall,
  input  logic              i_abort,
  output logic [3:0]        o_state,
  output logic [1:0]        o_layer_sel,
  output logic [ADDR_W-1:0] o_x_addr,
  output logic [ADDR_W-1:0] o_w_addr,
  output logic              o_mac_en,
  output logic              o_mac_clr,
  output logic              o_acc_valid,
  output logic              o_pool_en,
  output logic              o_busy,
  output logic              o_done
);
  localparam int MO = OUT1 > OUT2 ? (OUT1 > OUT3 ? OUT1 : OUT3) : (OUT2 > OUT3 ? OUT2 : OUT3);
  localparam int MT = K > POOL_LEN ? (K > FC_LEN ? K : FC_LEN) : (POOL_LEN > FC_LEN ? POOL_LEN : FC_LEN);
  localparam int OW = MO > 1 ? $clog2(MO) : 1;
  localparam int TW = MT > 1 ? $clog2(MT) : 1;
  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_CONV1 = 4'd1,
    S_POOL1 = 4'd2,
    S_CONV2 = 4'd3,
    S_CONV3 = 4'd4,
    S_FC    = 4'd5,
    S_DONE  = 4'd6
  } state_t;
  state_t          r_state, w_state_nxt, w_conv_nxt;
  logic [OW-1:0]   r_out_cnt, w_out_nxt;
  logic [TW-1:0]   r_tap_cnt, w_tap_nxt;
  logic            r_acc_valid;
  logic            w_conv, w_fc, w_mac_st, w_last_tap, w_last_out;
  assign w_conv     = r_state == S_CONV1 || r_state == S_CONV2 || r_state == S_CONV3;
  assign w_fc       = r_state == S_FC;
  assign w_mac_st   = w_conv || w_fc;
  assign w_last_tap = w_fc ? r_tap_cnt == TW'(FC_LEN - 1) : r_tap_cnt == TW'(K - 1);
  assign w_last_out = r_out_cnt == (r_state == S_CONV1 ? OW'(OUT1 - 1) :
                                    r_state == S_CONV2 ? OW'(OUT2 - 1) : OW'(OUT3 - 1));
  assign w_conv_nxt = r_state == S_CONV1 ? S_POOL1 : r_state == S_CONV2 ? S_CONV3 : S_FC;
  always_comb begin
    w_state_nxt = r_state;
    w_out_nxt   = r_out_cnt;
    w_tap_nxt   = r_tap_cnt;
    if (i_abort) begin
      w_state_nxt = S_IDLE;
      w_out_nxt   = '0;
      w_tap_nxt   = '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          w_state_nxt = S_CONV1;
          w_out_nxt   = '0;
          w_tap_nxt   = '0;
        end
        S_CONV1, S_CONV2, S_CONV3: if (!i_stall) begin
          w_tap_nxt = w_last_tap ? '0 : r_tap_cnt + 1'b1;
          if (w_last_tap) begin
            w_out_nxt   = w_last_out ? '0 : r_out_cnt + 1'b1;
            w_state_nxt = w_last_out ? w_conv_nxt : r_state;
          end
        end
        S_POOL1: if (!i_stall) begin
          w_tap_nxt   = r_tap_cnt == TW'(POOL_LEN - 1) ? '0 : r_tap_cnt + 1'b1;
          w_state_nxt = r_tap_cnt == TW'(POOL_LEN - 1) ? S_CONV2 : S_POOL1;
        end
        S_FC: if (!i_stall) begin
          w_tap_nxt   = w_last_tap ? '0 : r_tap_cnt + 1'b1;
          w_state_nxt = w_last_tap ? S_DONE : S_FC;
        end
        S_DONE: w_state_nxt = S_IDLE;
        default: begin
          w_state_nxt = S_IDLE;
          w_out_nxt   = '0;
          w_tap_nxt   = '0;
        end
      endcase
    end
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_out_cnt   <= '0;
      r_tap_cnt   <= '0;
      r_acc_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_out_cnt   <= w_out_nxt;
      r_tap_cnt   <= w_tap_nxt;
      r_acc_valid <= o_mac_en && w_last_tap;
    end
  end
  assign o_state     = r_state;
  assign o_layer_sel = r_state == S_CONV2 ? 2'd1 : r_state == S_CONV3 ? 2'd2 : w_fc ? 2'd3 : 2'd0;
  assign o_x_addr    = !w_mac_st ? '0 : w_fc ? ADDR_W'(r_tap_cnt) :
                       ADDR_W'(r_out_cnt) * ADDR_W'(STRIDE) + ADDR_W'(r_tap_cnt);
  // weight base is one kernel-length block per layer, indexed by the buffer select
  assign o_w_addr    = !w_mac_st ? '0 : ADDR_W'(K) * ADDR_W'(o_layer_sel) + ADDR_W'(r_tap_cnt);
  assign o_mac_en    = w_mac_st && !i_stall;
  assign o_mac_clr   = o_mac_en && r_tap_cnt == '0;
  assign o_acc_valid = r_acc_valid;
  assign o_pool_en   = r_state == S_POOL1 && !i_stall;
  assign o_busy      = r_state != S_IDLE && r_state != S_DONE;
  assign o_done      = r_state == S_DONE;
endmodule

// File: tb/tb_ecg_layer_sequencer.sv
// tb_ecg_layer_sequencer: scoreboard bench driving directed and random start/stall/abort/reset traffic.
module tb_ecg_layer_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, stall = 1'b0, abort = 1'b0;
  logic [3:0] state;
  logic [1:0] layer_sel;
  logic [9:0] x_addr, w_addr;
  logic mac_en, mac_clr, acc_valid, pool_en, busy, done;
  ecg_layer_sequencer dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_stall(stall), .i_abort(abort),
    .o_state(state), .o_layer_sel(layer_sel), .o_x_addr(x_addr), .o_w_addr(w_addr),
    .o_mac_en(mac_en), .o_mac_clr(mac_clr), .o_acc_valid(acc_valid), .o_pool_en(pool_en),
    .o_busy(busy), .o_done(done)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0] st;
    logic [1:0] ly;
    int x, w;
    bit clr, last, mac, pool;
  } work_t;
  typedef struct packed {
    logic [3:0] st;
    logic [1:0] ly;
    logic [9:0] x, w;
    logic mac, clr, acc, pool, busy, done;
  } exp_t;
  work_t prog[$];
  exp_t  sb[$];
  int total = 0, bad = 0;
  int m_mode = 0, m_idx = 0;
  bit m_acc = 0;
  int acc_cnt = 0;
  logic [3:0] prev_state = 4'd0;
  task automatic add(input int st, ly, x, w, bit clr, last, mac, pool);
    work_t e;
    e.st = 4'(st); e.ly = 2'(ly); e.x = x; e.w = w;
    e.clr = clr; e.last = last; e.mac = mac; e.pool = pool;
    prog.push_back(e);
  endtask
  task automatic add_conv(input int st, ly, n);
    for (int o = 0; o < n; o++)
      for (int t = 0; t < 3; t++) add(st, ly, o + t, 3 * ly + t, t == 0, t == 2, 1, 0);
  endtask
  task automatic step(input bit st, sl, ab);
    exp_t e;
    work_t w;
    bit nacc;
    @(posedge clk);
    #1;
    start = st; stall = sl; abort = ab;
    e = '0;
    e.acc = m_acc;
    nacc = 0;
    if (m_mode == 1) begin
      w = prog[m_idx];
      e.st = w.st; e.ly = w.ly; e.x = 10'(w.x); e.w = 10'(w.w);
      e.mac = w.mac && !sl; e.clr = e.mac && w.clr; e.pool = w.pool && !sl; e.busy = 1;
      nacc = w.mac && !sl && w.last;
    end else if (m_mode == 2) begin
      e.st = 4'd6; e.done = 1;
    end
    sb.push_back(e);
    if (ab) m_mode = 0;
    else if (m_mode == 0) begin
      if (st) begin m_mode = 1; m_idx = 0; end
    end else if (m_mode == 1) begin
      if (!sl) begin
        m_idx++;
        if (m_idx == prog.size()) m_mode = 2;
      end
    end else m_mode = 0;
    m_acc = nacc;
    if (!rst_n) begin m_mode = 0; m_acc = 0; end
  endtask
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (state != 4'd0 || mac_en || busy || acc_valid || x_addr != 10'd0) begin
      bad++;
      $display("FAIL async_reset: state=%0d mac_en=%0b busy=%0b acc=%0b x=%0d want all zero",
               state, mac_en, busy, acc_valid, x_addr);
    end
    m_mode = 0; m_acc = 0;
  endtask
  always @(negedge clk) begin
    exp_t a, e;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      a = {state, layer_sel, x_addr, w_addr, mac_en, mac_clr, acc_valid, pool_en, busy, done};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL cycle_out @%0t: got st=%0d ly=%0d x=%0d w=%0d mac=%0b clr=%0b acc=%0b pool=%0b busy=%0b done=%0b want st=%0d ly=%0d x=%0d w=%0d mac=%0b clr=%0b acc=%0b pool=%0b busy=%0b done=%0b",
                 $time, a.st, a.ly, a.x, a.w, a.mac, a.clr, a.acc, a.pool, a.busy, a.done,
                 e.st, e.ly, e.x, e.w, e.mac, e.clr, e.acc, e.pool, e.busy, e.done);
      end
    end
    if (state == 4'd1 && prev_state == 4'd0) acc_cnt = 0;
    if (acc_valid) acc_cnt++;
    if (done) begin
      total++;
      if (acc_cnt != 9) begin
        bad++;
        $display("FAIL acc_pulses: got %0d want 9", acc_cnt);
      end
    end
    prev_state = state;
  end
  initial begin
    add_conv(1, 0, 4);
    for (int t = 0; t < 2; t++) add(2, 0, 0, 0, 0, 0, 0, 1);
    add_conv(3, 1, 2);
    add_conv(4, 2, 2);
    for (int t = 0; t < 4; t++) add(5, 3, t, 9 + t, t == 0, t == 3, 1, 0);
    repeat (3) @(negedge clk);
    total++;
    if (state != 4'd0 || busy || done || mac_en || acc_valid || pool_en) begin
      bad++;
      $display("FAIL reset_state: state=%0d busy=%0b done=%0b mac=%0b acc=%0b pool=%0b want 0",
               state, busy, done, mac_en, acc_valid, pool_en);
    end
    rst_n = 1'b1;
    repeat (2) step(0, 0, 0);
    step(1, 0, 0);
    repeat (35) step(0, 0, 0);
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    repeat (3) step(0, 1, 0);
    repeat (35) step(0, 0, 0);
    step(1, 0, 0);
    repeat (22) step(0, 0, 0);
    step(0, 0, 1);
    repeat (5) step(0, 0, 0);
    step(1, 0, 0);
    repeat (35) step(0, 0, 0);
    repeat (70) step(1, 0, 0);
    repeat (40) step(0, 0, 0);
    step(1, 0, 0);
    repeat (28) step(0, 0, 0);
    async_reset();
    step(1, 0, 0);
    step(0, 1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step(0, 0, 0);
    repeat (400) step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 31) == 0);
    repeat (2) @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
